float_classify_pipe: RTL and testbench
======================================

Name: float_classify_pipe

Overview:
- Parametrised, pipelined successor of the combinational float classifier.
- Accepts a stream of IEEE-754-style words of configurable exponent/mantissa width via valid/ready handshake.
- Emits a one-hot class plus sign two cycles later, with full backpressure support.
- Optionally keeps saturating per-class statistics counters readable by a select port; sits between operand fetch and the FP exception/report logic.

Parameters:
- EXP_W, 8, exponent field width (>=2)
- MAN_W, 23, mantissa field width (>=1)
- CNT_W, 16, width of each statistics counter

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  block can accept a word this cycle
- in_data  in  EXP_W+MAN_W+1  {sign, exponent, mantissa}
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_type  out  5  one-hot class: bit0 zero, bit1 normal, bit2 subnormal, bit3 infinity, bit4 NaN
- out_sign  out  1  sign bit of the classified word
- cnt_clr  in  1  synchronous clear of all statistics counters
- cnt_sel  in  3  counter select: 0..4 = class bit index, 5 = total, 6/7 = reads 0
- cnt_value  out  CNT_W  selected counter value, combinational from cnt_sel

Behaviour:
- Reset (reset_n low, asynchronous): both stage-valid flags 0, out_valid 0, out_type 0, out_sign 0, all counters 0. Any in-flight data is dropped; nothing is emitted after release until new input.
- Stage 1 (S1) captures in_data on in_valid && in_ready.
- Stage 2 (S2) holds the classified result and drives out_valid/out_type/out_sign.
- Stage-advance rules:
  - s2_adv = !out_valid || out_ready
  - S1 moves to S2 when s1_valid && s2_adv
  - in_ready = !s1_valid || s2_adv (combinational from out_ready; intentional)
- Latency: a word accepted in cycle N appears with out_valid=1 in cycle N+2 when unstalled. Throughput: 1 word/cycle.
- Stall: while out_valid && !out_ready, out_type/out_sign stay stable. S1 holds one more word; in_ready drops once S1 is full.
- Classification in S1→S2 logic (e = exponent, m = mantissa):
  - e==0 && m==0: zero
  - e==0 && m!=0: subnormal
  - e all-ones && m==0: infinity
  - e all-ones && m!=0: NaN
  - otherwise: normal
- out_type is exactly one-hot whenever out_valid=1. It is 0 while out_valid=0 after reset. After a transfer with no new data it may hold its last value, but out_valid=0 marks it invalid.
- Sign is passed through for all classes, including NaN.
- Counters:
  - On out_valid && out_ready, the class counter and the total counter each increment by 1.
  - Counters saturate at 2^CNT_W-1; no wrap.
  - cnt_clr has priority over a same-cycle increment: result is 0.

Optional Feature:
- Macro FLOAT_CLASSIFY_STATS_EN.
- Defined: counters, cnt_clr and cnt_sel behave as above.
- Undefined: no counter registers are built; cnt_value is tied to 0; cnt_clr and cnt_sel are ignored. Pipeline behaviour is identical in both builds.

Test Plan:
- Reset then feed 0x00000000, 0x3F800000, 0x00000001, 0x7F800000, 0x7FC00000 back-to-back with out_ready=1 → out_type 00001, 00010, 00100, 01000, 10000 on cycles 2..6, one per cycle; in_ready stays 1.
- Feed 0x80000000 and 0xFF800000 → zero with sign 1, infinity with sign 1.
- Hold out_ready=0 and push 3 words → in_ready drops after 2 accepted. The first result stays stable on the outputs. Release out_ready → all 3 delivered in order, none lost or duplicated.
- EXP_W=5, MAN_W=10 build: 0x7C00 → infinity, 0x0200 → subnormal, 0x3C00 → normal.
- STATS_EN build, CNT_W=4: 20 normals → cnt_sel=1 reads 15 (saturated). cnt_clr asserted during a handshake → reads 0 next cycle. cnt_sel=5 counts total correctly.
- Assert reset_n low mid-stream with both stages full → out_valid falls immediately (asynchronously). After release, no stale output appears; the next input emerges 2 cycles after acceptance.

Source files
------------

// File: rtl/float_classify_pipe.sv
// Two-stage valid/ready float classifier: S1 registers the word, S2 holds the one-hot class and sign.
// Define FLOAT_CLASSIFY_STATS_EN to build saturating per-class and total counters behind cnt_sel.
module float_classify_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4:0]             out_type,
    output logic                   out_sign,
    input  logic                   cnt_clr,
    input  logic [2:0]             cnt_sel,
    output logic [CNT_W-1:0]       cnt_value
);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } word_t;

    logic [2:1] vld_pipe;
    word_t      s1_q;
    logic       s2_adv;
    logic       e_zero, e_ones, m_zero;
    logic [4:0] cls;

    assign out_valid = vld_pipe[2];
    assign s2_adv    = !vld_pipe[2] || out_ready;
    // in_ready looks straight through to out_ready so a full pipe still streams at 1 word/cycle.
    assign in_ready  = !vld_pipe[1] || s2_adv;

    assign e_zero = (s1_q.exp == '0);
    assign e_ones = &s1_q.exp;
    assign m_zero = (s1_q.man == '0);
    assign cls    = {e_ones & ~m_zero, e_ones & m_zero, e_zero & ~m_zero,
                     ~e_zero & ~e_ones, e_zero & m_zero};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            out_type <= '0;
            out_sign <= 1'b0;
        end else begin
            if (in_ready) vld_pipe[1] <= in_valid;
            if (in_valid && in_ready) s1_q <= word_t'(in_data);
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_type <= cls;
                    out_sign <= s1_q.sign;
                end
            end
        end
    end

`ifdef FLOAT_CLASSIFY_STATS_EN
    // Index 0..4 mirrors the out_type bit positions, index 5 is the total.
    logic [5:0][CNT_W-1:0] cnt_q;
    logic                  fire;

    assign fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (cnt_clr) begin
            cnt_q <= '0;
        end else if (fire) begin
            for (int i = 0; i < 5; i++)
                if (out_type[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            if (cnt_q[5] != '1) cnt_q[5] <= cnt_q[5] + CNT_W'(1);
        end
    end

    always_comb begin
        cnt_value = '0;
        case (cnt_sel)
            3'd0: cnt_value = cnt_q[0];
            3'd1: cnt_value = cnt_q[1];
            3'd2: cnt_value = cnt_q[2];
            3'd3: cnt_value = cnt_q[3];
            3'd4: cnt_value = cnt_q[4];
            3'd5: cnt_value = cnt_q[5];
            default: cnt_value = '0;
        endcase
    end
`else
    logic unused_stats;
    assign unused_stats = ^{cnt_clr, cnt_sel};
    assign cnt_value    = '0;
`endif

endmodule

// File: tb/tb_float_classify_pipe.sv
// Bench for float_classify_pipe: directed class patterns, stall, half-precision instance,
// statistics (model follows FLOAT_CLASSIFY_STATS_EN), randomized scoreboard run and async reset.
module tb_float_classify_pipe;
    localparam int EXP_W = 8, MAN_W = 23, CNT_W = 4, W = 32;
    localparam int CMAX = (1 << CNT_W) - 1;
`ifdef FLOAT_CLASSIFY_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0, reset_n = 1'b0;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_sign, cnt_clr = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [4:0] out_type;
    logic [2:0] cnt_sel = '0;
    logic [CNT_W-1:0] cnt_value;

    logic h_in_valid = 1'b0, h_in_ready, h_out_valid, h_out_sign;
    logic [15:0] h_in_data = '0;
    logic [4:0] h_out_type;
    logic [CNT_W-1:0] h_cnt_value;

    always #5 clk = ~clk;

    float_classify_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type), .out_sign(out_sign),
        .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .cnt_value(cnt_value));

    float_classify_pipe #(.EXP_W(5), .MAN_W(10), .CNT_W(CNT_W)) dut_h (
        .clk(clk), .reset_n(reset_n), .in_valid(h_in_valid), .in_ready(h_in_ready), .in_data(h_in_data),
        .out_valid(h_out_valid), .out_ready(1'b1), .out_type(h_out_type), .out_sign(h_out_sign),
        .cnt_clr(1'b0), .cnt_sel(3'd0), .cnt_value(h_cnt_value));

    int total = 0, bad = 0;
    logic [5:0] exp_q[$];
    int cnt_mdl[6];
    logic o_acc, o_dlv, o_valid, o_sign, o_inrdy;
    logic [4:0] o_type;
    logic [5:0] o_exp;
    logic [CNT_W-1:0] o_cnt;

    // Reference: {sign, one-hot class} from the field values as plain integers.
    function automatic logic [5:0] ref_class(input longint w, input int ew, input int mw);
        longint e, m, emax, s;
        logic [4:0] t;
        e    = (w >> mw) % (longint'(1) << ew);
        m    = w % (longint'(1) << mw);
        emax = (longint'(1) << ew) - 1;
        s    = (w >> (ew + mw)) % 2;
        if (e == 0)         t = (m == 0) ? 5'd1 : 5'd4;
        else if (e == emax) t = (m == 0) ? 5'd8 : 5'd16;
        else                t = 5'd2;
        return {s[0], t};
    endfunction

    function automatic int exp_cnt(input int sel);
        if (!STATS || sel > 5) return 0;
        return cnt_mdl[sel];
    endfunction

    // Drive one cycle on the negedge, sample before the posedge, advance the models after it.
    task automatic cyc(input logic v, input logic [W-1:0] d, input logic rdy, input logic clr);
        @(negedge clk);
        in_valid = v; in_data = d; out_ready = rdy; cnt_clr = clr;
        #1;
        o_acc = in_valid && in_ready; o_dlv = out_valid && out_ready;
        o_valid = out_valid; o_type = out_type; o_sign = out_sign; o_inrdy = in_ready;
        o_exp = 6'h3F;
        if (o_dlv && exp_q.size() > 0) o_exp = exp_q.pop_front();
        if (o_acc) exp_q.push_back(ref_class(longint'(d), EXP_W, MAN_W));
        @(posedge clk); #1;
        if (clr) begin
            for (int i = 0; i < 6; i++) cnt_mdl[i] = 0;
        end else if (o_dlv && o_exp != 6'h3F) begin
            for (int i = 0; i < 5; i++) if (o_exp[i] && cnt_mdl[i] < CMAX) cnt_mdl[i]++;
            if (cnt_mdl[5] < CMAX) cnt_mdl[5]++;
        end
    endtask

    task automatic rd(input int sel);
        cnt_sel = 3'(sel); #1; o_cnt = cnt_value;
    endtask

    task automatic test_reset;
        #12;
        total++; if ({out_valid, out_type, out_sign} !== 7'b0) begin bad++;
            $display("FAIL reset_outputs got v=%b t=%b s=%b want 0", out_valid, out_type, out_sign); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 8; s++) begin
            rd(s);
            total++; if (o_cnt !== '0) begin bad++; $display("FAIL reset_cnt sel=%0d got %0d want 0", s, o_cnt); end
        end
    endtask

    task automatic test_directed;
        logic [W-1:0] w[5] = '{32'h0000_0000, 32'h3F80_0000, 32'h0000_0001, 32'h7F80_0000, 32'h7FC0_0000};
        logic [4:0] t[5] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
        for (int k = 0; k < 7; k++) begin
            cyc(k < 5, (k < 5) ? w[k] : '0, 1'b1, 1'b0);
            total++; if (o_inrdy !== 1'b1) begin bad++; $display("FAIL dir_in_ready k=%0d got %b want 1", k, o_inrdy); end
            total++; if (o_valid !== (k >= 2)) begin bad++; $display("FAIL dir_valid k=%0d got %b want %b", k, o_valid, k >= 2); end
            if (k >= 2) begin
                total++; if ({o_sign, o_type} !== {1'b0, t[k-2]}) begin bad++;
                    $display("FAIL dir_type k=%0d got %b%b want 0%b", k, o_sign, o_type, t[k-2]); end
            end
        end
    endtask

    task automatic test_sign;
        logic [W-1:0] w[2] = '{32'h8000_0000, 32'hFF80_0000};
        logic [4:0] t[2] = '{5'b00001, 5'b01000};
        for (int k = 0; k < 4; k++) begin
            cyc(k < 2, (k < 2) ? w[k] : '0, 1'b1, 1'b0);
            if (k >= 2) begin
                total++; if ({o_valid, o_sign, o_type} !== {2'b11, t[k-2]}) begin bad++;
                    $display("FAIL sign_type k=%0d got v=%b s=%b t=%b want v=1 s=1 t=%b", k, o_valid, o_sign, o_type, t[k-2]); end
            end
        end
    endtask

    task automatic test_stall;
        logic [W-1:0] w[3] = '{32'h3F80_0000, 32'h7FC0_0001, 32'h8000_0010};
        int n_acc = 0, n_dlv = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b1, w[n_acc < 3 ? n_acc : 2], 1'b0, 1'b0);
            if (o_acc) n_acc++;
            if (k >= 2) begin
                total++; if ({o_valid, o_sign, o_type} !== {1'b1, ref_class(longint'(w[0]), EXP_W, MAN_W)}) begin bad++;
                    $display("FAIL stall_hold k=%0d got v=%b s=%b t=%b", k, o_valid, o_sign, o_type); end
            end
        end
        total++; if (n_acc !== 2 || o_inrdy !== 1'b0) begin bad++;
            $display("FAIL stall_accept got acc=%0d in_ready=%b want acc=2 in_ready=0", n_acc, o_inrdy); end
        for (int k = 0; k < 8; k++) begin
            cyc(n_acc < 3, w[n_acc < 3 ? n_acc : 2], 1'b1, 1'b0);
            if (o_acc) n_acc++;
            if (o_dlv) begin
                n_dlv++;
                total++; if ({o_sign, o_type} !== o_exp) begin bad++;
                    $display("FAIL stall_order got %b%b want %b", o_sign, o_type, o_exp); end
            end
        end
        total++; if (n_dlv !== 3 || exp_q.size() !== 0) begin bad++;
            $display("FAIL stall_count got dlv=%0d left=%0d want 3/0", n_dlv, exp_q.size()); end
    endtask

    task automatic test_half;
        logic [15:0] w[5] = '{16'h7C00, 16'h0200, 16'h3C00, 16'h0000, 16'hFE00};
        logic [5:0] e;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            h_in_valid = (k < 5); h_in_data = (k < 5) ? w[k] : '0;
            #1;
            if (k >= 2) begin
                e = ref_class(longint'(w[k-2]), 5, 10);
                total++; if ({h_out_valid, h_out_sign, h_out_type} !== {1'b1, e}) begin bad++;
                    $display("FAIL half_type k=%0d got v=%b s=%b t=%b want v=1 %b", k, h_out_valid, h_out_sign, h_out_type, e); end
            end
        end
        @(negedge clk); h_in_valid = 1'b0;
    endtask

    task automatic test_stats;
        cyc(1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 22; k++) cyc(k < 20, 32'h4000_0000 + W'(k), 1'b1, 1'b0);
        rd(1);
        total++; if (o_cnt !== CNT_W'(STATS ? CMAX : 0)) begin bad++; $display("FAIL stats_sat got %0d want %0d", o_cnt, STATS ? CMAX : 0); end
        rd(5);
        total++; if (o_cnt !== CNT_W'(exp_cnt(5))) begin bad++; $display("FAIL stats_total got %0d want %0d", o_cnt, exp_cnt(5)); end
        cyc(1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) cyc(k < 3, 32'h0000_0000, 1'b1, k == 3);
        for (int s = 0; s < 8; s++) begin
            rd(s);
            total++; if (o_cnt !== CNT_W'(exp_cnt(s))) begin bad++; $display("FAIL stats_clr sel=%0d got %0d want %0d", s, o_cnt, exp_cnt(s)); end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] d;
        int e;
        for (int k = 0; k < 500; k++) begin
            case ($urandom_range(0, 3))
                0: e = 0;
                1: e = 255;
                default: e = $urandom_range(1, 254);
            endcase
            d = {1'($urandom), 8'(e), ($urandom_range(0, 2) == 0) ? 23'd0 : 23'($urandom)};
            cyc($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
            if (o_valid && !$onehot(o_type)) begin
                total++; bad++; $display("FAIL rand_onehot k=%0d got %b", k, o_type);
            end
            if (o_dlv) begin
                total++; if ({o_sign, o_type} !== o_exp) begin bad++;
                    $display("FAIL rand_data k=%0d got %b%b want %b", k, o_sign, o_type, o_exp); end
            end
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            if (o_dlv) begin
                total++; if ({o_sign, o_type} !== o_exp) begin bad++;
                    $display("FAIL rand_drain got %b%b want %b", o_sign, o_type, o_exp); end
            end
        end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rand_left got %0d want 0", exp_q.size()); end
        for (int s = 0; s < 8; s++) begin
            rd(s);
            total++; if (o_cnt !== CNT_W'(exp_cnt(s))) begin bad++; $display("FAIL rand_cnt sel=%0d got %0d want %0d", s, o_cnt, exp_cnt(s)); end
        end
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'h3F80_0000, 1'b0, 1'b0);
        total++; if (!(out_valid === 1'b1 && in_ready === 1'b0)) begin bad++;
            $display("FAIL mid_full got v=%b in_ready=%b want 1/0", out_valid, in_ready); end
        #2; reset_n = 1'b0; #1;
        total++; if ({out_valid, out_type, out_sign} !== 7'b0) begin bad++;
            $display("FAIL mid_async got v=%b t=%b s=%b want 0", out_valid, out_type, out_sign); end
        exp_q.delete();
        for (int i = 0; i < 6; i++) cnt_mdl[i] = 0;
        @(negedge clk); in_valid = 1'b0; reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_stale k=%0d got %b want 0", k, o_valid); end
        end
        for (int k = 0; k < 4; k++) begin
            cyc(k == 0, 32'h0040_0000, 1'b1, 1'b0);
            total++; if (o_valid !== (k == 2)) begin bad++; $display("FAIL mid_latency k=%0d got %b want %b", k, o_valid, k == 2); end
            if (k == 2) begin
                total++; if ({o_sign, o_type} !== 6'b000100) begin bad++; $display("FAIL mid_type got %b%b want 000100", o_sign, o_type); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 6; i++) cnt_mdl[i] = 0;
        test_reset;
        test_directed;
        test_sign;
        test_stall;
        test_half;
        test_stats;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
